// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_pkg
// Purpose  : Shared widths, ALU opcodes, EX control bundle and forwarding
//            select encoding for the ID->EX pipeline register.
//            Build option: define ID_EX_FWD_EN to enable EX/MEM forwarding.
// Revision : 1.0  initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int OPW  = 4;

    localparam logic [OPW-1:0] OP_ADD   = 4'd0;
    localparam logic [OPW-1:0] OP_SUB   = 4'd1;
    localparam logic [OPW-1:0] OP_AND   = 4'd2;
    localparam logic [OPW-1:0] OP_OR    = 4'd3;
    localparam logic [OPW-1:0] OP_XOR   = 4'd4;
    localparam logic [OPW-1:0] OP_SLL   = 4'd5;
    localparam logic [OPW-1:0] OP_SRL   = 4'd6;
    localparam logic [OPW-1:0] OP_SRA   = 4'd7;
    localparam logic [OPW-1:0] OP_SLT   = 4'd8;
    localparam logic [OPW-1:0] OP_SLTU  = 4'd9;
    localparam logic [OPW-1:0] OP_PASSB = 4'd10;

`ifdef ID_EX_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic           valid;
        logic [OPW-1:0] op;
        logic           branch;
        logic [RAW-1:0] rd;
        logic           wen;
        logic           mem_rd;
    } ex_ctrl_t;

    // A bubble must never look like a taken branch or a register write.
    localparam ex_ctrl_t BUBBLE_CTRL = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_t;

    function automatic logic src_match(input logic           valid,
                                       input logic           wen,
                                       input logic [RAW-1:0] rd,
                                       input logic [RAW-1:0] rs);
        return valid && wen && (rd == rs) && (rs != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : ID-side instruction, producer bypass buses and registered EX
//            outputs of the ID->EX stage.
// Revision : 1.0  initial release
// ============================================================================
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic            id_valid;
    logic [OPW-1:0]  id_op;
    logic            id_branch;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [RAW-1:0]  id_rs1;
    logic [RAW-1:0]  id_rs2;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic            id_use_imm;
    logic [RAW-1:0]  id_rd;
    logic            id_wen;
    logic            id_mem_rd;

    logic [XLEN-1:0] ex_cal;
    logic            ex_if_branch;
    logic [RAW-1:0]  mem_rd;
    logic            mem_wen;
    logic [XLEN-1:0] mem_data;
    logic [RAW-1:0]  wb_rd;
    logic            wb_wen;
    logic [XLEN-1:0] wb_data;

    logic            id_stall;
    logic            ex_valid;
    logic [OPW-1:0]  ex_op;
    logic            ex_branch;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [RAW-1:0]  ex_rd;
    logic            ex_wen;
    logic            ex_mem_rd;

    modport master (
        output id_valid, id_op, id_branch, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
               id_rs1_val, id_rs2_val, id_imm, id_use_imm, id_rd, id_wen, id_mem_rd,
               ex_cal, ex_if_branch, mem_rd, mem_wen, mem_data, wb_rd, wb_wen, wb_data,
        input  id_stall, ex_valid, ex_op, ex_branch, ex_a, ex_b, ex_rd, ex_wen, ex_mem_rd
    );

    modport slave (
        input  id_valid, id_op, id_branch, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
               id_rs1_val, id_rs2_val, id_imm, id_use_imm, id_rd, id_wen, id_mem_rd,
               ex_cal, ex_if_branch, mem_rd, mem_wen, mem_data, wb_rd, wb_wen, wb_data,
        output id_stall, ex_valid, ex_op, ex_branch, ex_a, ex_b, ex_rd, ex_wen, ex_mem_rd
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_fwd_mux
// Purpose  : One source operand: producer match compare and priority select
//            EX > MEM > WB > regfile (EX/MEM only when forwarding is built in).
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  wire logic            i_use,
    input  wire logic [RAW-1:0]  i_rs,
    input  wire logic [XLEN-1:0] i_rf_val,
    input  wire logic            i_ex_valid,
    input  wire logic            i_ex_wen,
    input  wire logic            i_ex_is_load,
    input  wire logic [RAW-1:0]  i_ex_rd,
    input  wire logic [XLEN-1:0] i_ex_cal,
    input  wire logic            i_mem_wen,
    input  wire logic [RAW-1:0]  i_mem_rd,
    input  wire logic [XLEN-1:0] i_mem_data,
    input  wire logic            i_wb_wen,
    input  wire logic [RAW-1:0]  i_wb_rd,
    input  wire logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0]      o_operand,
    output logic                 o_ex_hit,
    output logic                 o_mem_hit
);

    logic     w_ex_hit;
    logic     w_mem_hit;
    logic     w_wb_hit;
    fwd_sel_t w_sel;

    assign w_ex_hit  = i_use && src_match(i_ex_valid, i_ex_wen, i_ex_rd, i_rs);
    assign w_mem_hit = i_use && src_match(1'b1, i_mem_wen, i_mem_rd, i_rs);
    assign w_wb_hit  = i_use && src_match(1'b1, i_wb_wen, i_wb_rd, i_rs);

    assign o_ex_hit  = w_ex_hit;
    assign o_mem_hit = w_mem_hit;

    // Later assignments override earlier ones, so the youngest producer wins.
    always_comb begin
        w_sel = FWD_RF;
        if (w_wb_hit) begin
            w_sel = FWD_WB;
        end
        if (FWD_EN && w_mem_hit) begin
            w_sel = FWD_MEM;
        end
        if (FWD_EN && w_ex_hit && !i_ex_is_load) begin
            w_sel = FWD_EX;
        end
    end

    always_comb begin
        case (w_sel)
            FWD_EX:  o_operand = i_ex_cal;
            FWD_MEM: o_operand = i_mem_data;
            FWD_WB:  o_operand = i_wb_data;
            default: o_operand = i_rf_val;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID->EX pipeline register with operand forwarding, hazard stall,
//            bubble insertion and taken-branch flush.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    id_ex_stage_if.slave bus
);

    ex_ctrl_t        r_ctrl;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;

    ex_ctrl_t        w_next_ctrl;
    logic [XLEN-1:0] w_next_a;
    logic [XLEN-1:0] w_next_b;

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic            w_a_ex_hit;
    logic            w_a_mem_hit;
    logic            w_b_ex_hit;
    logic            w_b_mem_hit;
    logic            w_use_b;
    logic            w_ex_hit;
    logic            w_mem_hit;
    logic            w_hazard;
    logic            w_flush;
    logic            w_stall;
    logic            w_bubble;

    // rs2 is not a real source when B comes from the immediate.
    assign w_use_b = bus.id_use_rs2 && !bus.id_use_imm;

    id_ex_stage_fwd_mux u_fwd_a (
        .i_use        (bus.id_use_rs1),
        .i_rs         (bus.id_rs1),
        .i_rf_val     (bus.id_rs1_val),
        .i_ex_valid   (r_ctrl.valid),
        .i_ex_wen     (r_ctrl.wen),
        .i_ex_is_load (r_ctrl.mem_rd),
        .i_ex_rd      (r_ctrl.rd),
        .i_ex_cal     (bus.ex_cal),
        .i_mem_wen    (bus.mem_wen),
        .i_mem_rd     (bus.mem_rd),
        .i_mem_data   (bus.mem_data),
        .i_wb_wen     (bus.wb_wen),
        .i_wb_rd      (bus.wb_rd),
        .i_wb_data    (bus.wb_data),
        .o_operand    (w_fwd_a),
        .o_ex_hit     (w_a_ex_hit),
        .o_mem_hit    (w_a_mem_hit)
    );

    id_ex_stage_fwd_mux u_fwd_b (
        .i_use        (w_use_b),
        .i_rs         (bus.id_rs2),
        .i_rf_val     (bus.id_rs2_val),
        .i_ex_valid   (r_ctrl.valid),
        .i_ex_wen     (r_ctrl.wen),
        .i_ex_is_load (r_ctrl.mem_rd),
        .i_ex_rd      (r_ctrl.rd),
        .i_ex_cal     (bus.ex_cal),
        .i_mem_wen    (bus.mem_wen),
        .i_mem_rd     (bus.mem_rd),
        .i_mem_data   (bus.mem_data),
        .i_wb_wen     (bus.wb_wen),
        .i_wb_rd      (bus.wb_rd),
        .i_wb_data    (bus.wb_data),
        .o_operand    (w_fwd_b),
        .o_ex_hit     (w_b_ex_hit),
        .o_mem_hit    (w_b_mem_hit)
    );

    assign w_ex_hit  = w_a_ex_hit  || w_b_ex_hit;
    assign w_mem_hit = w_a_mem_hit || w_b_mem_hit;

    // With forwarding only an EX load blocks; without it any EX/MEM producer must drain to WB.
    assign w_hazard = FWD_EN ? (w_ex_hit && r_ctrl.mem_rd) : (w_ex_hit || w_mem_hit);
    assign w_flush  = bus.ex_if_branch;
    assign w_stall  = bus.id_valid && w_hazard && !w_flush;
    assign w_bubble = !bus.id_valid || w_hazard || w_flush;

    assign bus.id_stall = w_stall;

    always_comb begin
        w_next_ctrl = BUBBLE_CTRL;
        w_next_a    = '0;
        w_next_b    = '0;
        if (!w_bubble) begin
            w_next_ctrl.valid  = 1'b1;
            w_next_ctrl.op     = bus.id_op;
            w_next_ctrl.branch = bus.id_branch;
            w_next_ctrl.rd     = bus.id_rd;
            w_next_ctrl.wen    = bus.id_wen;
            w_next_ctrl.mem_rd = bus.id_mem_rd;
            w_next_a           = w_fwd_a;
            w_next_b           = bus.id_use_imm ? bus.id_imm : w_fwd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= BUBBLE_CTRL;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            r_ctrl <= w_next_ctrl;
            r_a    <= w_next_a;
            r_b    <= w_next_b;
        end
    end

    assign bus.ex_valid  = r_ctrl.valid;
    assign bus.ex_op     = r_ctrl.op;
    assign bus.ex_branch = r_ctrl.branch;
    assign bus.ex_rd     = r_ctrl.rd;
    assign bus.ex_wen    = r_ctrl.wen;
    assign bus.ex_mem_rd = r_ctrl.mem_rd;
    assign bus.ex_a      = r_a;
    assign bus.ex_b      = r_b;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed-program bench for id_ex_stage with a small in-order
//            pipeline environment (EX ALU, MEM, WB, regfile) around it.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

`ifdef ID_EX_FWD_EN
    localparam bit TB_FWD = 1'b1;
`else
    localparam bit TB_FWD = 1'b0;
`endif

    typedef struct packed {
        logic            v;
        logic [OPW-1:0]  op;
        logic            br;
        logic            u1;
        logic            u2;
        logic            ui;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
        logic            wen;
        logic            ld;
        logic            taken;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] ldata;
    } ins_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if u_if ();
    id_ex_stage u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if));

    int checks = 0;
    int errors = 0;

    ins_t prog[$];
    int   tagq[$];
    int   next_tag = 0;

    // expected EX contents and downstream environment
    logic            m_v;
    ins_t            m_ins;
    logic [XLEN-1:0] m_a, m_b;
    int              m_tag;
    logic            mem_w, wb_w;
    logic [RAW-1:0]  mem_r, wb_r;
    logic [XLEN-1:0] mem_d, wb_d;
    logic [XLEN-1:0] rf [32];

    logic [XLEN-1:0] got_a [64];
    logic [XLEN-1:0] got_b [64];
    int              stalls [64];
    logic            flush_stall = 1'b1;
    logic            after_flush_valid = 1'b1;
    logic            flush_pending = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [OPW-1:0] op, input logic [RAW-1:0] rd,
                                input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                                input logic u1, input logic u2, input logic ui,
                                input logic [XLEN-1:0] imm, input logic ld,
                                input logic taken, input logic [XLEN-1:0] ldata);
        ins_t x;
        x = '0;
        x.v = 1'b1; x.op = op; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
        x.u1 = u1; x.u2 = u2; x.ui = ui; x.imm = imm; x.wen = 1'b1;
        x.ld = ld; x.taken = taken; x.ldata = ldata;
        return x;
    endfunction

    function automatic int push(input ins_t x);
        prog.push_back(x);
        tagq.push_back(next_tag);
        next_tag++;
        return next_tag - 1;
    endfunction

    task automatic nops(input int n);
        int t;
        for (int i = 0; i < n; i++) t = push('0);
    endtask

    function automatic logic [XLEN-1:0] alu(input logic [OPW-1:0] op,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (op)
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_PASSB: return b;
            default:  return a + b;
        endcase
    endfunction

    // value an instruction in ID must see for register rs, given what is still in flight
    function automatic logic [XLEN-1:0] see(input logic use_, input logic [RAW-1:0] rs,
                                            input logic [XLEN-1:0] excal);
        if (!use_ || rs == 0) return rf[rs];
        if (TB_FWD && m_v && m_ins.wen && m_ins.rd == rs && !m_ins.ld) return excal;
        if (TB_FWD && mem_w && mem_r == rs) return mem_d;
        if (wb_w && wb_r == rs) return wb_d;
        return rf[rs];
    endfunction

    function automatic logic must_wait(input logic use_, input logic [RAW-1:0] rs);
        logic in_ex, in_mem;
        if (!use_ || rs == 0) return 1'b0;
        in_ex  = m_v && m_ins.wen && m_ins.rd == rs;
        in_mem = mem_w && mem_r == rs;
        return TB_FWD ? (in_ex && m_ins.ld) : (in_ex || in_mem);
    endfunction

    task automatic clear_model();
        m_v = 0; m_ins = '0; m_a = 0; m_b = 0; m_tag = 0;
        mem_w = 0; mem_r = 0; mem_d = 0; wb_w = 0; wb_r = 0; wb_d = 0;
    endtask

    task automatic drive(input ins_t c, input logic [XLEN-1:0] excal, input logic fl);
        u_if.id_valid = c.v;      u_if.id_op = c.op;        u_if.id_branch = c.br;
        u_if.id_use_rs1 = c.u1;   u_if.id_use_rs2 = c.u2;   u_if.id_use_imm = c.ui;
        u_if.id_rs1 = c.rs1;      u_if.id_rs2 = c.rs2;      u_if.id_imm = c.imm;
        u_if.id_rs1_val = rf[c.rs1]; u_if.id_rs2_val = rf[c.rs2];
        u_if.id_rd = c.rd;        u_if.id_wen = c.wen;      u_if.id_mem_rd = c.ld;
        u_if.ex_cal = excal;      u_if.ex_if_branch = fl;
        u_if.mem_wen = mem_w;     u_if.mem_rd = mem_r;      u_if.mem_data = mem_d;
        u_if.wb_wen = wb_w;       u_if.wb_rd = wb_r;        u_if.wb_data = wb_d;
    endtask

    task automatic step();
        ins_t c; int ctag; logic have, fl, st, issue;
        logic [XLEN-1:0] excal, na, nb;
        @(negedge clk);
        have  = prog.size() > 0;
        c     = have ? prog[0] : '0;
        ctag  = have ? tagq[0] : 0;
        excal = alu(m_ins.op, m_a, m_b);
        fl    = m_v && m_ins.taken;
        drive(c, excal, fl);
        st    = c.v && !fl && (must_wait(c.u1, c.rs1) || must_wait(c.u2 && !c.ui, c.rs2));
        issue = c.v && !fl && !st;
        na    = see(c.u1, c.rs1, excal);
        nb    = c.ui ? c.imm : see(c.u2, c.rs2, excal);
        #1;
        chk("id_stall", {63'd0, u_if.id_stall}, {63'd0, st});
        chk("ex_ctrl", {51'd0, u_if.ex_valid, u_if.ex_op, u_if.ex_branch, u_if.ex_rd,
                        u_if.ex_wen, u_if.ex_mem_rd},
                       {51'd0, m_v, m_ins.op, m_ins.br, m_ins.rd, m_ins.wen, m_ins.ld});
        chk("ex_a", {32'd0, u_if.ex_a}, {32'd0, m_a});
        chk("ex_b", {32'd0, u_if.ex_b}, {32'd0, m_b});
        if (m_v) begin
            got_a[m_tag] = u_if.ex_a;
            got_b[m_tag] = u_if.ex_b;
        end
        if (c.v && u_if.id_stall) stalls[ctag]++;
        if (flush_pending) after_flush_valid = u_if.ex_valid;
        flush_pending = fl && c.v;
        if (fl && c.v) flush_stall = u_if.id_stall;
        @(posedge clk);
        if (wb_w && wb_r != 0) rf[wb_r] = wb_d;
        wb_w = mem_w; wb_r = mem_r; wb_d = mem_d;
        mem_w = m_v && m_ins.wen; mem_r = m_ins.rd; mem_d = m_ins.ld ? m_ins.ldata : excal;
        if (issue) begin
            m_v = 1; m_ins = c; m_a = na; m_b = nb; m_tag = ctag;
        end else begin
            m_v = 0; m_ins = '0; m_a = 0; m_b = 0; m_tag = 0;
        end
        if (have && (!c.v || fl || issue)) begin
            void'(prog.pop_front());
            void'(tagq.pop_front());
        end
    endtask

    task automatic run();
        for (int n = 0; n < 300 && prog.size() > 0; n++) step();
        if (prog.size() > 0) chk("program_timeout", 64'(prog.size()), 64'd0);
        repeat (4) step();
    endtask

    int t_sub, t_use, t_r0, t_sq, t_or, t_post, t_tmp;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = XLEN'(i * 32'h100);
        rf[0] = 0; rf[1] = 32'd10; rf[2] = 32'd20;
        for (int i = 0; i < 64; i++) begin stalls[i] = 0; got_a[i] = 'x; got_b[i] = 'x; end
        clear_model();
        rst_n = 1'b0;
        drive('0, '0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", {63'd0, u_if.id_stall}, 64'd0);
        chk("reset_ctrl", {51'd0, u_if.ex_valid, u_if.ex_op, u_if.ex_branch, u_if.ex_rd,
                           u_if.ex_wen, u_if.ex_mem_rd}, 64'd0);
        chk("reset_ab", {u_if.ex_a, u_if.ex_b}, 64'd0);
        rst_n = 1'b1;

        t_tmp = push(mk(OP_ADD, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 0));        // ADD x3,x1,x2
        t_sub = push(mk(OP_SUB, 5'd4, 5'd3, 5'd1, 1, 1, 0, 0, 0, 0, 0));        // SUB x4,x3,x1
        nops(3);
        t_tmp = push(mk(OP_ADD, 5'd5, 5'd1, 5'd0, 1, 0, 1, 4, 1, 0, 32'h55));   // LW x5
        t_use = push(mk(OP_ADD, 5'd6, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, 0));        // ADD x6,x5,x5
        nops(3);
        t_tmp = push(mk(OP_PASSB, 5'd0, 5'd0, 5'd0, 0, 0, 1, 32'h1234, 0, 0, 0)); // write x0
        t_r0  = push(mk(OP_ADD, 5'd10, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 0));       // read x0
        nops(3);
        t_tmp = push(mk(OP_ADD, 5'd8, 5'd1, 5'd0, 1, 0, 1, 8, 1, 1, 32'h99));   // load that flushes
        t_sq  = push(mk(OP_ADD, 5'd9, 5'd8, 5'd1, 1, 1, 0, 0, 0, 0, 0));        // squashed user
        nops(3);
        t_tmp = push(mk(OP_PASSB, 5'd3, 5'd0, 5'd0, 0, 0, 1, 32'h77, 0, 0, 0)); // x3 = 0x77
        t_or  = push(mk(OP_OR, 5'd7, 5'd3, 5'd3, 1, 1, 0, 0, 0, 0, 0));         // OR x7,x3,x3
        run();

        chk("t1_sub_a", {32'd0, got_a[t_sub]}, 64'd30);
        chk("t1_sub_b", {32'd0, got_b[t_sub]}, 64'd10);
        chk("t1_sub_stalls", 64'(stalls[t_sub]), TB_FWD ? 64'd0 : 64'd2);
        chk("t2_use_a", {32'd0, got_a[t_use]}, 64'h55);
        chk("t2_use_b", {32'd0, got_b[t_use]}, 64'h55);
        chk("t2_use_stalls", 64'(stalls[t_use]), TB_FWD ? 64'd1 : 64'd2);
        chk("t3_x0_a", {32'd0, got_a[t_r0]}, 64'd0);
        chk("t3_x0_stalls", 64'(stalls[t_r0]), 64'd0);
        chk("t4_flush_stall", {63'd0, flush_stall}, 64'd0);
        chk("t4_after_flush_valid", {63'd0, after_flush_valid}, 64'd0);
        chk("t4_squashed_stalls", 64'(stalls[t_sq]), 64'd0);
        chk("t5_or_a", {32'd0, got_a[t_or]}, 64'h77);
        chk("t5_or_b", {32'd0, got_b[t_or]}, 64'h77);
        chk("t5_or_stalls", 64'(stalls[t_or]), TB_FWD ? 64'd0 : 64'd2);

        // asynchronous reset with a live instruction in EX
        t_tmp = push(mk(OP_ADD, 5'd11, 5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 0));
        step();
        #1;
        chk("t6_pre_reset_valid", {63'd0, u_if.ex_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        clear_model();
        drive('0, '0, 1'b0);
        #1;
        chk("t6_reset_ctrl", {51'd0, u_if.ex_valid, u_if.ex_op, u_if.ex_branch, u_if.ex_rd,
                              u_if.ex_wen, u_if.ex_mem_rd}, 64'd0);
        chk("t6_reset_ab", {u_if.ex_a, u_if.ex_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        t_post = push(mk(OP_ADD, 5'd13, 5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 0));
        run();
        chk("t6_post_a", {32'd0, got_a[t_post]}, 64'd10);
        chk("t6_post_b", {32'd0, got_b[t_post]}, 64'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
